mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS32 core.
- Sequences the shared datapath (PC, IR, GRF, ALU, EXT, DM) through FETCH/DECODE/EXE/MEM/WB, one instruction at a time.
- Replaces the single-cycle combinational controller.
- Adds a data-memory ready handshake with a watchdog timeout.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for mem_ready in a MEM state before aborting; legal range 1..255.
- CW, 8, width of the watchdog counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; held stable by the datapath from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU equal flag, valid in EXE.
- mem_ready  in  1  DM access complete, sampled in MEM_RD/MEM_WR.
- pc_wr  out  1  PC load enable.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 GPR[rs].
- ir_wr  out  1  IR load enable.
- reg_wr  out  1  GRF write enable.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- wd_src  out  2  00 ALU result, 01 DM read data, 10 PC (already PC+4).
- alu_src  out  1  0 GPR[rt], 1 EXT output.
- alu_op  out  3  000 add, 001 sub, 010 or, 011 pass-B.
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 load-upper.
- mem_rd  out  1  DM read strobe.
- mem_wr  out  1  DM write strobe.
- instr_done  out  1  one-cycle pulse in an instruction's last cycle.
- err_timeout  out  1  sticky; set on watchdog expiry, cleared only by reset.
- state  out  3  current state, for debug.

Behaviour:
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop (sll $0). Any other opcode/funct decodes as nop.
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM_RD=3, MEM_WR=4, WB=5. Registered state. Outputs are combinational from state plus decoded class.
- While reset is low:
  - state=FETCH, watchdog=0, err_timeout=0.
  - All enables/strobes (pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, instr_done) forced 0.
  - Mux selects read 0.
- After reset deasserts, the first edge executes FETCH.
- FETCH: ir_wr=1, pc_wr=1, pc_src=00. Always goes to DECODE.
- DECODE:
  - j: pc_wr=1, pc_src=10, instr_done=1, then FETCH.
  - nop/illegal: instr_done=1, then FETCH.
  - jal: goes to WB.
  - All others go to EXE.
- EXE:
  - R-type: alu_src=0; addu alu_op=000, subu alu_op=001. Then WB.
  - ori: alu_src=1, ext_op=00, alu_op=010. Then WB.
  - lui: ext_op=10, alu_op=011. Then WB.
  - lw/sw: ext_op=01, alu_op=000. lw goes to MEM_RD, sw to MEM_WR.
  - beq: alu_op=001; pc_wr=zero, pc_src=01, instr_done=1, then FETCH.
  - jr: pc_wr=1, pc_src=11, instr_done=1, then FETCH.
- MEM_RD / MEM_WR: mem_rd (resp. mem_wr) held high while waiting; watchdog increments each cycle mem_ready=0.
  - mem_ready=1: MEM_RD goes to WB. MEM_WR asserts instr_done and goes to FETCH. Watchdog clears.
  - Watchdog reaches TIMEOUT-1 with mem_ready=0: err_timeout<=1, state<=FETCH, watchdog<=0, no GRF write, no instr_done. PC already advanced, so the instruction is skipped.
  - If mem_ready=1 arrives on the expiry cycle, completion wins.
- WB: reg_wr=1, instr_done=1, then FETCH.
  - R-type: reg_dst=01, wd_src=00.
  - ori/lui: reg_dst=00, wd_src=00.
  - lw: reg_dst=00, wd_src=01.
  - jal: reg_dst=10, wd_src=10, plus pc_wr=1, pc_src=10.
- Cycle counts: j 2; beq/jr/jal 3; R-type/ori/lui 4; sw 4+w; lw 5+w, where w = mem_ready wait cycles.
- Reset asserted mid-instruction: immediate abort. No partial reg_wr/mem_wr after reset falls.

Decomposition:
- Package mc_pkg:
  - State encodings.
  - Opcode constants: R=000000, ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
  - Funct constants: addu=100001, subu=100011, jr=001000.
  - alu_op, ext_op, pc_src, reg_dst and wd_src codes.
- Sub-module mc_decode: combinational opcode/funct to one-hot instruction class. mc_ctrl instantiates it and holds the FSM and watchdog.

Test Plan:
- addu $3,$1,$2 (funct 100001): states 0,1,2,5. WB has reg_wr=1, reg_dst=01, wd_src=00. instr_done is high only in the 4th cycle.
- lw with mem_ready low 3 cycles: MEM_RD lasts 4 cycles with mem_rd=1. WB has wd_src=01. Total 8 cycles; err_timeout stays 0.
- beq with zero=1, then with zero=0: EXE pc_wr=1/pc_src=01 in the first case, pc_wr=0 in the second. Both take 3 cycles.
- jal then jr: jal WB has pc_wr=1, pc_src=10, reg_dst=10, wd_src=10. jr EXE has pc_src=11. Each takes 3 cycles.
- sw with mem_ready never high, TIMEOUT=16: mem_wr high 16 cycles, then err_timeout=1 and state=FETCH. Next fetch proceeds; err_timeout stays 1 until reset.
- reset low during MEM_RD, and illegal opcode 111111: reset gives all strobes 0 the same cycle and state=0, with FETCH on the first edge after release. The illegal opcode completes in 2 cycles with no writes.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS32 controller:
// state encodings, opcode/funct constants, datapath select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_WB     = 3'd5
    } state_e;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    // One-hot instruction class; unsupported encodings land in nop.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic nop;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct to one-hot instruction class.
// Ports: opcode_i, funct_i in; cls_o one-hot class out.
import mc_pkg::*;

module mc_decode (
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output iclass_t    cls_o
);

    always_comb begin
        cls_o = '0;
        unique case (opcode_i)
            OP_R: begin
                unique case (funct_i)
                    FN_ADDU: cls_o.addu = 1'b1;
                    FN_SUBU: cls_o.subu = 1'b1;
                    FN_JR:   cls_o.jr   = 1'b1;
                    default: cls_o.nop  = 1'b1;
                endcase
            end
            OP_ORI:  cls_o.ori = 1'b1;
            OP_LUI:  cls_o.lui = 1'b1;
            OP_LW:   cls_o.lw  = 1'b1;
            OP_SW:   cls_o.sw  = 1'b1;
            OP_BEQ:  cls_o.beq = 1'b1;
            OP_J:    cls_o.j   = 1'b1;
            OP_JAL:  cls_o.jal = 1'b1;
            default: cls_o.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: FETCH/DECODE/EXE/MEM/WB sequencing with a
// data-memory ready watchdog. Ports: clk, reset (async, active-low),
// opcode/funct/zero/mem_ready in; datapath enables, selects,
// instr_done, sticky err_timeout and debug state out.
import mc_pkg::*;

module mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_src,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       instr_done,
    output logic       err_timeout,
    output logic [2:0] state
);

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    iclass_t       cls;
    state_e        state_q, state_d;
    logic [CW-1:0] wd_q, wd_d;
    logic          err_q, err_d;

    logic       pc_wr_c, ir_wr_c, reg_wr_c;
    logic       mem_rd_c, mem_wr_c, done_c, alu_src_c;
    logic [1:0] pc_src_c, reg_dst_c, wd_src_c, ext_op_c;
    logic [2:0] alu_op_c;

    mc_decode u_dec (
        .opcode_i (opcode),
        .funct_i  (funct),
        .cls_o    (cls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        err_d     = err_q;
        pc_wr_c   = 1'b0;
        ir_wr_c   = 1'b0;
        reg_wr_c  = 1'b0;
        mem_rd_c  = 1'b0;
        mem_wr_c  = 1'b0;
        done_c    = 1'b0;
        alu_src_c = 1'b0;
        pc_src_c  = PC_PLUS4;
        reg_dst_c = RD_RT;
        wd_src_c  = WD_ALU;
        ext_op_c  = EXT_ZERO;
        alu_op_c  = ALU_ADD;

        unique case (state_q)
            S_FETCH: begin
                ir_wr_c = 1'b1;
                pc_wr_c = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    cls.j: begin
                        pc_wr_c  = 1'b1;
                        pc_src_c = PC_JUMP;
                        done_c   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    cls.nop: begin
                        done_c  = 1'b1;
                        state_d = S_FETCH;
                    end
                    cls.jal: state_d = S_WB;
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                unique case (1'b1)
                    cls.addu: state_d = S_WB;
                    cls.subu: begin
                        alu_op_c = ALU_SUB;
                        state_d  = S_WB;
                    end
                    cls.ori: begin
                        alu_src_c = 1'b1;
                        alu_op_c  = ALU_OR;
                        state_d   = S_WB;
                    end
                    cls.lui: begin
                        alu_src_c = 1'b1;
                        ext_op_c  = EXT_LUI;
                        alu_op_c  = ALU_PASSB;
                        state_d   = S_WB;
                    end
                    cls.lw: begin
                        alu_src_c = 1'b1;
                        ext_op_c  = EXT_SIGN;
                        state_d   = S_MEM_RD;
                    end
                    cls.sw: begin
                        alu_src_c = 1'b1;
                        ext_op_c  = EXT_SIGN;
                        state_d   = S_MEM_WR;
                    end
                    cls.beq: begin
                        alu_op_c = ALU_SUB;
                        pc_wr_c  = zero;
                        pc_src_c = PC_BRANCH;
                        done_c   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    cls.jr: begin
                        pc_wr_c  = 1'b1;
                        pc_src_c = PC_REG;
                        done_c   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_rd_c = (state_q == S_MEM_RD);
                mem_wr_c = (state_q == S_MEM_WR);
                // Completion beats expiry when both land together.
                if (mem_ready) begin
                    wd_d    = '0;
                    done_c  = mem_wr_c;
                    state_d = mem_rd_c ? S_WB : S_FETCH;
                end else if (wd_q == WD_LAST) begin
                    wd_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wd_d = wd_q + CW'(1);
                end
            end
            S_WB: begin
                reg_wr_c = 1'b1;
                done_c   = 1'b1;
                state_d  = S_FETCH;
                unique case (1'b1)
                    cls.addu, cls.subu: reg_dst_c = RD_RD;
                    cls.lw:             wd_src_c  = WD_MEM;
                    cls.jal: begin
                        reg_dst_c = RD_RA;
                        wd_src_c  = WD_PC;
                        pc_wr_c   = 1'b1;
                        pc_src_c  = PC_JUMP;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_FETCH;
        endcase
    end

    // FETCH is the reset state, so its strobes must be masked while
    // reset is held to keep the datapath quiet.
    assign pc_wr       = reset & pc_wr_c;
    assign ir_wr       = reset & ir_wr_c;
    assign reg_wr      = reset & reg_wr_c;
    assign mem_rd      = reset & mem_rd_c;
    assign mem_wr      = reset & mem_wr_c;
    assign instr_done  = reset & done_c;
    assign alu_src     = reset & alu_src_c;
    assign pc_src      = reset ? pc_src_c : '0;
    assign reg_dst     = reset ? reg_dst_c : '0;
    assign wd_src      = reset ? wd_src_c : '0;
    assign ext_op      = reset ? ext_op_c : '0;
    assign alu_op      = reset ? alu_op_c : '0;
    assign err_timeout = err_q;
    assign state       = state_q;

endmodule
